// File: rtl/bitcount_unit_pkg.sv
// Shared types for the bit-counting coprocessor: operation modes and FSM states.
// Mode encodings match the instruction decoder's 2-bit mode field.
package bitcount_unit_pkg;

    typedef enum logic [1:0] {
        BC_POP1 = 2'b00,
        BC_POP0 = 2'b01,
        BC_CTZ  = 2'b10,
        BC_CLZ  = 2'b11
    } bc_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } bc_state_e;

    // CLZ is executed as CTZ on a bit-reversed operand, so both share one datapath.
    function automatic logic is_tz_mode(input bc_mode_e m);
        return (m == BC_CTZ) || (m == BC_CLZ);
    endfunction

endpackage

// File: rtl/bitcount_chunk.sv
// Combinational per-chunk evaluator: population count, trailing-zero count
// (CHUNK when the chunk is all zero) and a non-zero flag.
module bitcount_chunk #(
    parameter int CHUNK = 8,
    parameter int CW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] chunk,
    output logic [CW-1:0]    ones,
    output logic [CW-1:0]    tz,
    output logic             nz
);

    // Population count of the chunk.
    always_comb begin
        ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            ones = ones + CW'(chunk[i]);
        end
    end

    // Trailing zeros: scan from the MSB down so the lowest set bit wins.
    always_comb begin
        tz = CW'(CHUNK);
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk[i]) begin
                tz = CW'(i);
            end else begin
                tz = tz;
            end
        end
    end

    // Non-zero flag marks the chunk that terminates a CTZ/CLZ scan.
    always_comb begin
        nz = |chunk;
    end

endmodule

// File: rtl/bitcount_unit.sv
// Multi-cycle bit-counting coprocessor: POPCNT1/POPCNT0/CTZ/CLZ over WIDTH bits,
// CHUNK bits per cycle, fixed latency WIDTH/CHUNK, start/busy/done handshake.
module bitcount_unit
    import bitcount_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] numin,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] numout
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CW    = $clog2(CHUNK + 1);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    bc_state_e        state_q, state_d;
    bc_mode_e         mode_q, mode_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             found_q, found_d;
    logic [OUT_W-1:0] numout_q, numout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] rev_s;
    logic [WIDTH-1:0] load_s;
    logic [OUT_W-1:0] acc_step_s;
    logic             found_step_s;
    logic             last_s;
    logic [CW-1:0]    ch_ones_s;
    logic [CW-1:0]    ch_tz_s;
    logic             ch_nz_s;

    bitcount_chunk #(
        .CHUNK (CHUNK),
        .CW    (CW)
    ) u_chunk (
        .chunk (opnd_q[CHUNK-1:0]),
        .ones  (ch_ones_s),
        .tz    (ch_tz_s),
        .nz    (ch_nz_s)
    );

    // Bit-reversed operand for CLZ.
    always_comb begin
        rev_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_s[i] = numin[WIDTH-1-i];
        end
    end

    // Operand pre-conditioning: POPCNT0 counts ones of the inverse, CLZ scans the reverse.
    always_comb begin
        load_s = numin;
        case (bc_mode_e'(mode))
            BC_POP0: load_s = ~numin;
            BC_CLZ:  load_s = rev_s;
            default: load_s = numin;
        endcase
    end

    // Accumulator/found update for the chunk currently at the bottom of the operand.
    always_comb begin
        acc_step_s   = acc_q;
        found_step_s = found_q;
        if (!is_tz_mode(mode_q)) begin
            acc_step_s = acc_q + OUT_W'(ch_ones_s);
        end else if (!found_q) begin
            acc_step_s   = acc_q + OUT_W'(ch_tz_s);
            found_step_s = ch_nz_s;
        end else begin
            acc_step_s = acc_q;
        end
    end

    // Last-chunk detect.
    always_comb begin
        last_s = (cnt_q == CNT_W'(N - 1));
    end

    // FSM next state and datapath next values.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        found_d  = found_q;
        numout_d = numout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = bc_mode_e'(mode);
                    opnd_d  = load_s;
                    cnt_d   = '0;
                    acc_d   = '0;
                    found_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                opnd_d  = opnd_q >> CHUNK;
                cnt_d   = cnt_q + CNT_W'(1);
                acc_d   = acc_step_s;
                found_d = found_step_s;
                if (last_s) begin
                    numout_d = acc_step_s;
                    state_d  = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= BC_POP1;
            opnd_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            found_q  <= 1'b0;
            numout_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            found_q  <= found_d;
            numout_q <= numout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign numout = numout_q;

endmodule

// File: tb/tb_bitcount_unit.sv
// Directed self-checking bench for bitcount_unit (32/8 and 16/4 instances).
module tb_bitcount_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] numin;
    logic        busy;
    logic        done;
    logic [5:0]  numout;

    logic        start16;
    logic [1:0]  mode16;
    logic [15:0] numin16;
    logic        busy16;
    logic        done16;
    logic [4:0]  numout16;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] M_POP1 = 2'b00;
    localparam logic [1:0] M_POP0 = 2'b01;
    localparam logic [1:0] M_CTZ  = 2'b10;
    localparam logic [1:0] M_CLZ  = 2'b11;

    bitcount_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .numin  (numin),
        .busy   (busy),
        .done   (done),
        .numout (numout)
    );

    bitcount_unit #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk    (clk),
        .reset  (reset),
        .start  (start16),
        .mode   (mode16),
        .numin  (numin16),
        .busy   (busy16),
        .done   (done16),
        .numout (numout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one 32-bit operation from a negedge and check busy length, done pulse and result.
    task automatic run_op(input logic [1:0] m, input logic [31:0] v, input logic [5:0] exp, input string nm);
        int cyc;
        start = 1'b1;
        mode  = m;
        numin = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        numin = ~v;
        cyc = 0;
        while (busy && cyc < 20) begin
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_and_done: done=%b required 0", nm, done);
            end
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required 4", nm, cyc);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b required 1", nm, done);
        end
        checks++;
        if (numout !== exp) begin
            errors++;
            $display("FAIL %s numout: got %0d required %0d", nm, numout, exp);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: busy=%b done=%b required 0 0", nm, busy, done);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        mode    = M_POP1;
        numin   = 32'h0;
        start16 = 1'b0;
        mode16  = M_POP1;
        numin16 = 16'h0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || numout !== 6'd0) begin
            errors++;
            $display("FAIL reset32: busy=%b done=%b numout=%0d required 0 0 0", busy, done, numout);
        end
        checks++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || numout16 !== 5'd0) begin
            errors++;
            $display("FAIL reset16: busy=%b done=%b numout=%0d required 0 0 0", busy16, done16, numout16);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_popcnt();
        run_op(M_POP1, 32'hFFFF_FFFF, 6'd32, "pop1_ones");
        run_op(M_POP1, 32'h8000_0001, 6'd2,  "pop1_ends");
        run_op(M_POP0, 32'h0000_000F, 6'd28, "pop0_f");
        run_op(M_POP0, 32'hFFFF_FFFF, 6'd0,  "pop0_ones");
        run_op(M_POP1, 32'h1234_5678, 6'd13, "pop1_mixed");
    endtask

    task automatic test_ctz_clz();
        run_op(M_CTZ, 32'h0001_0000, 6'd16, "ctz_bit16");
        run_op(M_CLZ, 32'h0001_0000, 6'd15, "clz_bit16");
        run_op(M_CLZ, 32'h8000_0000, 6'd0,  "clz_msb");
        run_op(M_CTZ, 32'h8000_0000, 6'd31, "ctz_msb");
        run_op(M_CTZ, 32'h0000_0100, 6'd8,  "ctz_chunk_edge");
        run_op(M_CLZ, 32'h0000_0001, 6'd31, "clz_lsb");
    endtask

    task automatic test_zero_operand();
        run_op(M_CTZ, 32'h0000_0000, 6'd32, "ctz_zero");
        run_op(M_CLZ, 32'h0000_0000, 6'd32, "clz_zero");
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        mode  = M_POP1;
        numin = 32'h0000_0007;
        @(posedge clk);
        // Junk request held through every busy cycle must be ignored.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b1;
            mode  = M_CLZ;
            numin = 32'hFFFF_0000;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_busy%0d: busy=%b required 1", k, busy);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || numout !== 6'd3) begin
            errors++;
            $display("FAIL b2b_first: done=%b busy=%b numout=%0d required 1 0 3", done, busy, numout);
        end
        start = 1'b1;
        mode  = M_POP1;
        numin = 32'h0000_00FF;
        @(negedge clk);
        start = 1'b0;
        numin = 32'h0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b required 1 0", busy, done);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (numout !== 6'd3 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_hold%0d: numout=%0d busy=%b required 3 1", k, numout, busy);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || numout !== 6'd8) begin
            errors++;
            $display("FAIL b2b_second: done=%b numout=%0d required 1 8", done, numout);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        mode  = M_POP1;
        numin = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy: busy=%b required 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || numout !== 6'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b numout=%0d required 0 0 0", busy, done, numout);
        end
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || numout !== 6'd0) begin
            errors++;
            $display("FAIL midrun_discard: busy=%b done=%b numout=%0d required 0 0 0", busy, done, numout);
        end
        run_op(M_POP1, 32'h8000_0001, 6'd2, "after_reset");
    endtask

    task automatic test_width16();
        int cyc;
        start16 = 1'b1;
        mode16  = M_POP1;
        numin16 = 16'hA5A5;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        numin16 = 16'h0;
        cyc = 0;
        while (busy16 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL w16_busy_cycles: got %0d required 4", cyc);
        end
        checks++;
        if (done16 !== 1'b1 || numout16 !== 5'd8) begin
            errors++;
            $display("FAIL w16_pop1: done=%b numout=%0d required 1 8", done16, numout16);
        end
        start16 = 1'b1;
        mode16  = M_CLZ;
        numin16 = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        cyc = 0;
        while (busy16 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (done16 !== 1'b1 || numout16 !== 5'd16) begin
            errors++;
            $display("FAIL w16_clz_zero: done=%b numout=%0d required 1 16", done16, numout16);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_popcnt();
        test_ctz_clz();
        test_zero_operand();
        test_back_to_back();
        test_reset_mid_run();
        test_width16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
